// File: rtl/hex_byte_parser.sv
// hex_byte_parser: pairs ASCII hex digits from uart_rx into bytes and queues them in a FWFT FIFO.
module hex_byte_parser #(
    parameter int FIFO_AW = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       hi_pending,
    output logic       err,
    output logic       overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic {S_HI, S_LO} state_t;
    state_t state, state_n;
    logic [3:0] hi, hi_n, nib;
    logic is_hex, is_dig, is_sep, push, err_n, full, pop, wr_en, ovf_n;
    logic [7:0] push_byte;
    logic [7:0] mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0] count;
    always_comb begin
        is_dig = rx_data inside {[8'h30:8'h39]};
        is_hex = is_dig || (rx_data inside {[8'h41:8'h46], [8'h61:8'h66]});
        is_sep = rx_data inside {8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C};
        // letters A-F/a-f carry 1..6 in their low nibble
        nib = is_dig ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    end
    always_comb begin
        state_n   = state;
        hi_n      = hi;
        push      = 1'b0;
        push_byte = 8'h00;
        err_n     = 1'b0;
        if (rx_valid) begin
            if (state == S_HI) begin
                hi_n    = is_hex ? nib : hi;
                state_n = is_hex ? S_LO : S_HI;
                err_n   = !is_hex && !is_sep;
            end else begin
                state_n   = S_HI;
                push      = is_hex || is_sep;
                push_byte = is_hex ? {hi, nib} : {4'h0, hi};
                err_n     = !is_hex && !is_sep;
            end
        end
    end
    always_comb begin
        out_valid  = count != '0;
        out_data   = out_valid ? mem[rd_ptr] : 8'h00;
        hi_pending = state == S_LO;
        full       = count == (FIFO_AW + 1)'(DEPTH);
        pop        = out_valid && out_ready;
        wr_en      = push && (!full || pop);
        ovf_n      = push && full && !pop;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_HI;
            hi       <= 4'h0;
            err      <= 1'b0;
            overflow <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            hi       <= hi_n;
            err      <= err_n;
            overflow <= ovf_n;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            count <= count + (FIFO_AW + 1)'(wr_en) - (FIFO_AW + 1)'(pop);
        end
    end
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= push_byte;
    end
endmodule

// File: tb/tb_hex_byte_parser.sv
// tb_hex_byte_parser: scoreboard bench for hex_byte_parser with a queue-level reference model.
module tb_hex_byte_parser;
    logic CLK = 1'b0, RST = 1'b0, rx_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic out_valid, hi_pending, err, overflow;
    logic [7:0] out_data;
    int n_vec = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    logic [2:0] flag_q[$];
    logic [2:0] mf;
    int pend = -1, occ = 0, occ_vis = 0;

    always #5 CLK = ~CLK;

    hex_byte_parser #(.FIFO_AW(2)) dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_data(rx_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .hi_pending(hi_pending), .err(err), .overflow(overflow)
    );

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
        return -1;
    endfunction

    function automatic bit sep(input logic [7:0] c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0D || c == 8'h0A || c == 8'h2C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the model by one clock edge.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy);
        int h;
        bit push, drop, e, pop;
        logic [7:0] b;
        rx_valid = v; rx_data = d; out_ready = rdy;
        push = 0; e = 0; b = 8'h00; h = hexval(d);
        if (v) begin
            if (pend < 0) begin
                if (h >= 0) pend = h;
                else if (!sep(d)) e = 1;
            end else begin
                if (h >= 0) begin push = 1; b = 8'(pend * 16 + h); end
                else if (sep(d)) begin push = 1; b = 8'(pend); end
                else e = 1;
                pend = -1;
            end
        end
        pop  = occ > 0 && rdy;
        drop = push && occ == 4 && !pop;
        if (push && !drop) exp_q.push_back(b);
        occ = occ - int'(pop) + int'(push && !drop);
        @(posedge CLK); #2;
        flag_q.push_back({e, drop, pend >= 0});
        occ_vis = occ;
    endtask

    task automatic send(input string s, input logic rdy);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        RST = 1'b1; rx_valid = 1'b0; out_ready = 1'b0; rx_data = 8'h00;
        exp_q.delete(); flag_q.delete();
        pend = -1; occ = 0; occ_vis = 0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_hi_pending", hi_pending, 0);
        chk("rst_err", err, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge CLK); #2;
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            chk("out_valid", out_valid, occ_vis != 0);
            if (flag_q.size() > 0) begin
                mf = flag_q.pop_front();
                chk("err", err, mf[2]);
                chk("overflow", overflow, mf[1]);
                chk("hi_pending", hi_pending, mf[0]);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL spurious_byte: got %0h expected none at %0t", out_data, $time);
                end else chk("out_data", out_data, exp_q.pop_front());
            end else if (!out_valid) chk("idle_data", out_data, 0);
        end
    end

    initial begin
        logic [7:0] c;
        int rp;
        string hx = "0123456789abcdefABCDEF";
        string sp = " \t\r\n,";
        #2;
        do_reset();
        send("41", 1'b1); idle(2, 1'b1);
        send("aF 7\n", 1'b1); idle(2, 1'b1);
        send("G", 1'b1); send("3x", 1'b1); send("55", 1'b1); idle(2, 1'b1);
        send("1122334455", 1'b0); idle(2, 1'b0); idle(6, 1'b1);
        send("12345678", 1'b0); step(1'b1, "9", 1'b0); step(1'b1, "9", 1'b1);
        idle(1, 1'b0); idle(6, 1'b1);
        send("8", 1'b1);
        do_reset();
        send("99", 1'b1); idle(3, 1'b1);
        rp = 2;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) rp = $urandom_range(0, 4);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: c = hx[$urandom_range(0, 21)];
                5, 6: c = sp[$urandom_range(0, 4)];
                7: begin
                    c = 8'($urandom);
                    if (hexval(c) >= 0 || sep(c)) c = "G";
                end
                default: c = 8'h00;
            endcase
            step(c != 8'h00 && $urandom_range(0, 3) != 0, c, $urandom_range(0, 3) < rp);
        end
        idle(10, 1'b1);
        chk("drained", exp_q.size(), 0);
        @(negedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
